// File: rtl/rom_fetch_arbiter.sv
// Two-port arbiter sharing a combinational-read instruction ROM; registered request and response.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority + wait guard.
module rom_fetch_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned WAIT_W   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_i,
    input  logic [AW-1:0] addr0_i,
    output logic          gnt0_o,
    output logic          rvalid0_o,
    output logic [DW-1:0] rdata0_o,
    input  logic          req1_i,
    input  logic [AW-1:0] addr1_i,
    output logic          gnt1_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata1_o,
    output logic          rom_ce_o,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_data_i
);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1} state_e;

    state_e        state_q, state_d;
    logic          win0, win1;
    logic          rom_ce_q;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          gnt0_q, gnt1_q;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

`ifdef ARB_ROUND_ROBIN_EN
    // Last winner: 1 means port 1 won last, so port 0 takes the next contention.
    logic last_q, last_d;
`else
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (req0_i && req1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (last_q) win0 = 1'b1;
            else        win1 = 1'b1;
`else
            if (wait_q == WAIT_W'(MAX_WAIT)) win1 = 1'b1;
            else                             win0 = 1'b1;
`endif
        end else if (req0_i) begin
            win0 = 1'b1;
        end else if (req1_i) begin
            win1 = 1'b1;
        end
    end

    always_comb begin
        state_d    = StIdle;
        rom_addr_d = rom_addr_q;
        if (win0) begin
            state_d    = StAcc0;
            rom_addr_d = addr0_i;
        end else if (win1) begin
            state_d    = StAcc1;
            rom_addr_d = addr1_i;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        last_d = last_q;
        if (win0)      last_d = 1'b0;
        else if (win1) last_d = 1'b1;
    end
`else
    // Counts edges on which a pending port-1 request loses; saturates at MAX_WAIT.
    always_comb begin
        wait_d = wait_q;
        if (!req1_i || win1) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rom_ce_q   <= 1'b0;
            rom_addr_q <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`else
            wait_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rom_ce_q   <= win0 | win1;
            rom_addr_q <= rom_addr_d;
            gnt0_q     <= win0;
            gnt1_q     <= win1;
            rvalid0_q  <= (state_q == StAcc0);
            rvalid1_q  <= (state_q == StAcc1);
            if (state_q == StAcc0) rdata0_q <= rom_data_i;
            if (state_q == StAcc1) rdata1_q <= rom_data_i;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`else
            wait_q     <= wait_d;
`endif
        end
    end

    assign rom_ce_o   = rom_ce_q;
    assign rom_addr_o = rom_addr_q;
    assign gnt0_o     = gnt0_q;
    assign gnt1_o     = gnt1_q;
    assign rvalid0_o  = rvalid0_q;
    assign rvalid1_o  = rvalid1_q;
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a small behavioural ROM on the ROM port.
// Contention expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_rom_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, rom_ce;
    logic [31:0] rdata0, rdata1, rom_addr, rom_data;
    logic [31:0] rom_mem [16];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr[5:2]];

    rom_fetch_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_i    (req0),
        .addr0_i   (addr0),
        .gnt0_o    (gnt0),
        .rvalid0_o (rvalid0),
        .rdata0_o  (rdata0),
        .req1_i    (req1),
        .addr1_i   (addr1),
        .gnt1_o    (gnt1),
        .rvalid1_o (rvalid1),
        .rdata1_o  (rdata1),
        .rom_ce_o  (rom_ce),
        .rom_addr_o(rom_addr),
        .rom_data_i(rom_data)
    );

    // Advance one edge; outputs are sampled 1 time unit later, inputs driven then too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h4; addr1 = 32'h8;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({gnt0, gnt1, rvalid0, rvalid1, rom_ce} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl cyc%0d got %b want 00000", i,
                         {gnt0, gnt1, rvalid0, rvalid1, rom_ce});
            end
            vectors++;
            if ({rom_addr, rdata0, rdata1} !== 96'b0) begin
                miscompares++;
                $display("FAIL reset_data cyc%0d addr=%h rd0=%h rd1=%h want 0", i,
                         rom_addr, rdata0, rdata1);
            end
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step();
        vectors++;
        if ({gnt0, gnt1, rvalid0, rvalid1, rom_ce} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_after got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, rom_ce});
        end
    endtask

    task automatic test_single();
        req0 = 1'b1; addr0 = 32'h0000_0004;
        step();
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== 32'h4
            || rvalid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_gnt gnt0=%b gnt1=%b ce=%b addr=%h rv0=%b want 1 0 1 4 0",
                     gnt0, gnt1, rom_ce, rom_addr, rvalid0);
        end
        req0 = 1'b0;
        step();
        vectors++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'h3401_1100 || gnt0 !== 1'b0 || rom_ce !== 1'b0
            || rom_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL single_rsp rv0=%b rd0=%h gnt0=%b ce=%b addr=%h want 1 34011100 0 0 4",
                     rvalid0, rdata0, gnt0, rom_ce, rom_addr);
        end
        step();
        vectors++;
        if (rvalid0 !== 1'b0 || rdata0 !== 32'h3401_1100 || rvalid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_hold rv0=%b rd0=%h rv1=%b want 0 34011100 0",
                     rvalid0, rdata0, rvalid1);
        end
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; addr0 = 32'h0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k < 4) begin
                vectors++;
                if (gnt0 !== 1'b1 || rom_addr !== 32'(4 * k)) begin
                    miscompares++;
                    $display("FAIL b2b_gnt k=%0d gnt0=%b addr=%h want 1 %h", k, gnt0, rom_addr,
                             32'(4 * k));
                end
            end
            vectors++;
            if (k >= 1 && k <= 4) begin
                if (rvalid0 !== 1'b1 || rdata0 !== rom_mem[k-1]) begin
                    miscompares++;
                    $display("FAIL b2b_rsp k=%0d rv0=%b rd0=%h want 1 %h", k, rvalid0, rdata0,
                             rom_mem[k-1]);
                end
            end else if (rvalid0 !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_rv_idle k=%0d rv0=%b want 0", k, rvalid0);
            end
            if (k < 3) addr0 = 32'(4 * (k + 1));
            else       req0 = 1'b0;
        end
    endtask

    task automatic test_contention();
        logic exp1 [10];
        logic prev1;
        // Fresh arbiter state so the first contention starts from reset.
        rst = 1'b1; step(); rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        req0 = 1'b1; addr0 = 32'h10; req1 = 1'b1; addr1 = 32'h20;
        prev1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if (gnt1 !== exp1[k] || gnt0 !== !exp1[k]) begin
                miscompares++;
                $display("FAIL cont_gnt k=%0d gnt0=%b gnt1=%b want %b %b", k, gnt0, gnt1,
                         !exp1[k], exp1[k]);
            end
            if (k > 0) begin
                vectors++;
                if (rvalid1 !== prev1 || rvalid0 !== !prev1
                    || (prev1 && rdata1 !== rom_mem[8]) || (!prev1 && rdata0 !== rom_mem[4]))
                begin
                    miscompares++;
                    $display("FAIL cont_rsp k=%0d rv0=%b rv1=%b rd0=%h rd1=%h", k, rvalid0,
                             rvalid1, rdata0, rdata1);
                end
            end
            prev1 = exp1[k];
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_access();
        req1 = 1'b1; addr1 = 32'h8;
        step();
        vectors++;
        if (gnt1 !== 1'b1 || rom_addr !== 32'h8) begin
            miscompares++;
            $display("FAIL midrst_gnt gnt1=%b addr=%h want 1 8", gnt1, rom_addr);
        end
        rst = 1'b1; req1 = 1'b0;
        step();
        vectors++;
        if (rvalid1 !== 1'b0 || rom_ce !== 1'b0 || gnt1 !== 1'b0 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_drop rv1=%b ce=%b gnt1=%b rd1=%h want 0 0 0 0", rvalid1,
                     rom_ce, gnt1, rdata1);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_after rv0=%b rv1=%b want 0 0", rvalid0, rvalid1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = 32'hA5C0_0000 + 32'(i * 32'h111);
        rom_mem[1] = 32'h3401_1100;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
